tetris_cmd_arbiter: RTL and testbench

- Turns two input sources into one ordered stream of game commands for game_control_unit:
  - PS/2 scan-code bytes (set 2);
  - debounced push-button pulses.
- Decodes make, break and extended (E0) sequences.
- Arbitrates between sources when both arrive together.
- Buffers commands in a small FIFO and hands them over with a valid/ready handshake.
- Replaces the ad-hoc held-level key register in the top level. Sits between PS2_Controller/key and game_control_unit in the clk_100m domain.

---
 rtl/tetris_cmd_arbiter.sv | 230 +++++++++++++++++++++++
 tb/tb_tetris_cmd_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tetris_cmd_arbiter.sv
// tetris_cmd_arbiter: merges PS/2 set-2 scan codes and debounced button
// pulses into one ordered command stream for the game controller.
// Commands are one-hot: bit0 rotate, bit1 down, bit2 left, bit3 right.
// Optional feature macro: TETRIS_CMD_ARBITER_AUTO_REPEAT_EN re-enqueues a held
// PS/2 key REPEAT_DELAY cycles after its make, then every REPEAT_PERIOD cycles.
module tetris_cmd_arbiter #(
  parameter int FIFO_DEPTH    = 4,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    ps2_data,
  input  logic                          ps2_valid,
  input  logic [3:0]                    btn_pulse,
  input  logic                          cmd_ready,
  output logic                          cmd_valid,
  output logic [3:0]                    cmd_op,
  output logic [7:0]                    last_code,
  output logic [3:0]                    led,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [7:0]                    drop_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 and at least 2");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("REPEAT_DELAY and REPEAT_PERIOD must be positive");
  end

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} parse_state_t;

  parse_state_t     state, state_nxt;
  logic [3:0]       ps2_op;
  logic             brk_match;
  logic             held_valid, held_ext;
  logic [7:0]       held_code;
  logic [3:0]       skid_op, skid_nxt;
  logic [3:0]       btn_op;
  logic             btn_any;
  logic [2:0]       btn_extra;
  logic [3:0]       arb_op, wr_op;
  logic             lost;
  logic             rpt_fire;
  logic [3:0]       rpt_op;
  logic [3:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             full, pop, wr_en, full_drop;
  logic [2:0]       drop_inc;
  logic [8:0]       drop_sum;

  // Set-2 make code (plain or E0-extended) to one-hot command; 0 if unmapped.
  function automatic logic [3:0] map_code(input logic [7:0] code, input logic ext);
    logic [3:0] op;
    op = 4'b0000;
    if (ext) begin
      case (code)
        8'h75:   op = 4'b0001;
        8'h72:   op = 4'b0010;
        8'h6B:   op = 4'b0100;
        8'h74:   op = 4'b1000;
        default: op = 4'b0000;
      endcase
    end else begin
      case (code)
        8'h1D:   op = 4'b0001;
        8'h1B:   op = 4'b0010;
        8'h1C:   op = 4'b0100;
        8'h23:   op = 4'b1000;
        default: op = 4'b0000;
      endcase
    end
    return op;
  endfunction

  // Parser state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Parser next state: advances only on a received byte.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_nxt = state;
    if (ps2_valid) begin
      case (state)
        IDLE:    state_nxt = (ps2_data == 8'hE0) ? EXT :
                             (ps2_data == 8'hF0) ? BRK : IDLE;
        EXT:     state_nxt = (ps2_data == 8'hF0) ? EXT_BRK : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Parser outputs: make command and break-matches-held-key flag.
  always_comb begin
    ps2_op    = '0;
    brk_match = 1'b0;
    if (ps2_valid) begin
      case (state)
        IDLE:         ps2_op = map_code(ps2_data, 1'b0);
        EXT:          ps2_op = map_code(ps2_data, 1'b1);
        BRK, EXT_BRK: brk_match = held_valid && (held_ext == (state == EXT_BRK))
                                  && (ps2_data == held_code);
        default:      ;
      endcase
    end
  end

  // Button priority: the lowest set bit wins, the rest are counted as drops.
  always_comb begin
    btn_any   = (btn_pulse != 4'b0000);
    btn_op    = btn_pulse & (~btn_pulse + 4'd1);
    btn_extra = 3'(btn_pulse[0]) + 3'(btn_pulse[1]) + 3'(btn_pulse[2])
              + 3'(btn_pulse[3]) - (btn_any ? 3'd1 : 3'd0);
  end

  // Write arbitration: skid, then button, then PS/2. The runner-up goes to
  // the skid register and a third contender is lost.
  always_comb begin
    arb_op   = '0;
    skid_nxt = '0;
    lost     = 1'b0;
    if (skid_op != 4'b0000) begin
      arb_op = skid_op;
      if (btn_any) begin
        skid_nxt = btn_op;
        lost     = (ps2_op != 4'b0000);
      end else begin
        skid_nxt = ps2_op;
      end
    end else if (btn_any) begin
      arb_op   = btn_op;
      skid_nxt = ps2_op;
    end else begin
      arb_op = ps2_op;
    end
    wr_op = (arb_op != 4'b0000) ? arb_op : (rpt_fire ? rpt_op : 4'b0000);
  end

`ifdef TETRIS_CMD_ARBITER_AUTO_REPEAT_EN
  logic [31:0] rpt_cnt;
  logic        rpt_first_done;

  assign rpt_op   = map_code(held_code, held_ext);
  assign rpt_fire = held_valid &&
                    (rpt_cnt == (rpt_first_done ? 32'(REPEAT_PERIOD) : 32'(REPEAT_DELAY)));

  // Repeat timer: counts cycles since the make or since the last repeat.
  always_ff @(posedge clk) begin
    if (rst || brk_match) begin
      rpt_cnt        <= '0;
      rpt_first_done <= 1'b0;
    end else if (ps2_op != 4'b0000) begin
      rpt_cnt        <= 32'd1;
      rpt_first_done <= 1'b0;
    end else if (rpt_fire) begin
      rpt_cnt        <= 32'd1;
      rpt_first_done <= 1'b1;
    end else if (held_valid) begin
      rpt_cnt <= rpt_cnt + 32'd1;
    end
  end
`else
  assign rpt_op   = 4'b0000;
  assign rpt_fire = 1'b0;
`endif

  // FIFO handshake and drop accounting.
  always_comb begin
    cmd_valid = (fifo_count != '0);
    cmd_op    = cmd_valid ? mem[rd_ptr] : 4'b0000;
    full      = (fifo_count == CNT_W'(FIFO_DEPTH));
    pop       = cmd_valid && cmd_ready;
    full_drop = (wr_op != 4'b0000) && full && !pop;
    wr_en     = (wr_op != 4'b0000) && !full_drop;
    drop_inc  = btn_extra + 3'(lost) + 3'(full_drop);
    drop_sum  = {1'b0, drop_cnt} + 9'(drop_inc);
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is not reset; fifo_count gates cmd_op, so stale
    // entries are never visible.
    if (wr_en) mem[wr_ptr] <= wr_op;
  end

  // Control registers: pointers, occupancy, skid, held key, status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      skid_op    <= '0;
      held_valid <= 1'b0;
      held_ext   <= 1'b0;
      held_code  <= '0;
      last_code  <= '0;
      led        <= '0;
      drop_cnt   <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        led    <= wr_op;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (wr_en && !pop)      fifo_count <= fifo_count + CNT_W'(1);
      else if (!wr_en && pop) fifo_count <= fifo_count - CNT_W'(1);
      skid_op <= skid_nxt;
      if (ps2_op != 4'b0000) begin
        held_valid <= 1'b1;
        held_code  <= ps2_data;
        held_ext   <= (state == EXT);
      end else if (brk_match) begin
        held_valid <= 1'b0;
      end
      if (ps2_valid && ps2_data != 8'hE0 && ps2_data != 8'hF0) last_code <= ps2_data;
      drop_cnt <= (drop_sum > 9'd255) ? 8'd255 : drop_sum[7:0];
    end
  end

endmodule

// File: tb/tb_tetris_cmd_arbiter.sv
// Testbench for tetris_cmd_arbiter: directed scenarios plus random traffic,
// checked against a queue-based reference model and a pop scoreboard.
module tb_tetris_cmd_arbiter;
  localparam int DEPTH = 4;
  localparam int RD    = 10;
  localparam int RP    = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] ps2_data = '0;
  logic       ps2_valid = 1'b0;
  logic [3:0] btn_pulse = '0;
  logic       cmd_ready = 1'b0;
  logic       cmd_valid;
  logic [3:0] cmd_op;
  logic [7:0] last_code;
  logic [3:0] led;
  logic [2:0] fifo_count;
  logic [7:0] drop_cnt;

  tetris_cmd_arbiter #(.FIFO_DEPTH(DEPTH), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clk(clk), .rst(rst), .ps2_data(ps2_data), .ps2_valid(ps2_valid),
    .btn_pulse(btn_pulse), .cmd_ready(cmd_ready), .cmd_valid(cmd_valid),
    .cmd_op(cmd_op), .last_code(last_code), .led(led),
    .fifo_count(fifo_count), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model state.
  logic [3:0] m_fifo[$];
  logic [3:0] m_skid;
  int         m_drop;
  logic [3:0] m_led;
  logic [7:0] m_last;
  bit         m_ext, m_brk, m_held_v, m_held_ext;
  logic [7:0] m_held_code;
  int         m_age;
  logic [3:0] exp_q[$];

  // Snapshot of the expected outputs for the cycle being driven.
  bit         mon_en = 0;
  logic       s_valid;
  logic [3:0] s_head, s_led;
  logic [2:0] s_count;
  logic [7:0] s_drop, s_last;

  function automatic logic [3:0] key_op(input logic [7:0] b, input bit ext);
    if (ext) begin
      case (b)
        8'h75: return 4'b0001; 8'h72: return 4'b0010;
        8'h6B: return 4'b0100; 8'h74: return 4'b1000;
        default: return 4'b0000;
      endcase
    end
    case (b)
      8'h1D: return 4'b0001; 8'h1B: return 4'b0010;
      8'h1C: return 4'b0100; 8'h23: return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic model_reset();
    m_fifo.delete();
    m_skid = 0; m_drop = 0; m_led = 0; m_last = 0;
    m_ext = 0; m_brk = 0; m_held_v = 0; m_held_ext = 0; m_held_code = 0; m_age = 0;
  endtask

  // One clock cycle: drive inputs, snapshot expectations, advance the model.
  task automatic cycle(input bit r, input bit pv, input logic [7:0] pd,
                       input logic [3:0] bp, input bit rdy);
    logic [3:0] cands[$];
    logic [3:0] pcmd, fire_op, wr;
    bit fire;
    rst = r; ps2_valid = pv; ps2_data = pd; btn_pulse = bp; cmd_ready = rdy;
    s_valid = (m_fifo.size() != 0);
    s_head  = s_valid ? m_fifo[0] : 4'b0000;
    s_count = 3'(m_fifo.size());
    s_drop  = 8'(m_drop);
    s_led   = m_led;
    s_last  = m_last;
    mon_en  = 1;
    if (s_valid && rdy) exp_q.push_back(m_fifo[0]);
    if (r) begin
      model_reset();
    end else begin
      fire = 0;
      fire_op = key_op(m_held_code, m_held_ext);
`ifdef TETRIS_CMD_ARBITER_AUTO_REPEAT_EN
      if (m_held_v) begin
        fire = (m_age == RD) || (m_age > RD && (m_age - RD) % RP == 0);
        m_age++;
      end
`endif
      pcmd = 0;
      if (pv) begin
        if (pd != 8'hE0 && pd != 8'hF0) m_last = pd;
        if (m_brk) begin
          if (m_held_v && m_held_code == pd && m_held_ext == m_ext) m_held_v = 0;
          m_brk = 0; m_ext = 0;
        end else if (pd == 8'hF0) begin
          m_brk = 1;
        end else if (pd == 8'hE0 && !m_ext) begin
          m_ext = 1;
        end else begin
          pcmd = key_op(pd, m_ext);
          if (pcmd != 0) begin
            m_held_v = 1; m_held_code = pd; m_held_ext = m_ext; m_age = 1;
          end
          m_ext = 0;
        end
      end
      if (m_skid != 0) cands.push_back(m_skid);
      if (bp != 0) begin
        for (int i = 0; i < 4; i++) begin
          if (bp[i]) begin
            if (cands.size() == 0 || cands[cands.size()-1] != (4'b0001 << i) ||
                (m_skid != 0 && cands.size() == 1))
              ;
          end
        end
        begin
          int first;
          first = -1;
          for (int i = 0; i < 4; i++) if (bp[i] && first < 0) first = i;
          cands.push_back(4'(1 << first));
          for (int i = first + 1; i < 4; i++) if (bp[i]) m_drop++;
        end
      end
      if (pcmd != 0) cands.push_back(pcmd);
      if (cands.size() == 0 && fire) cands.push_back(fire_op);
      wr = (cands.size() > 0) ? cands[0] : 4'b0000;
      m_skid = (cands.size() > 1) ? cands[1] : 4'b0000;
      if (cands.size() > 2) m_drop += cands.size() - 2;
      if (m_fifo.size() > 0 && rdy) void'(m_fifo.pop_front());
      if (wr != 0) begin
        if (m_fifo.size() < DEPTH) begin m_fifo.push_back(wr); m_led = wr; end
        else m_drop++;
      end
      if (m_drop > 255) m_drop = 255;
    end
    @(posedge clk); #1;
  endtask

  // Monitor: compares status every cycle and pops the scoreboard on handshakes.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("cmd_valid", cmd_valid, s_valid);
        check("cmd_op", cmd_op, s_head);
        check("fifo_count", fifo_count, s_count);
        check("drop_cnt", drop_cnt, s_drop);
        check("led", led, s_led);
        check("last_code", last_code, s_last);
        if (cmd_valid && cmd_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL pop_op: got %0h expected no command", cmd_op);
          end else begin
            check("pop_op", cmd_op, exp_q.pop_front());
          end
        end
      end
    end
  end

  function automatic logic [7:0] rand_byte();
    logic [7:0] tbl [10];
    tbl = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74};
    if ($urandom_range(0, 9) == 0) return 8'($urandom);
    return tbl[$urandom_range(0, 9)];
  endfunction

  initial begin
    @(posedge clk); #1;
    // Reset state.
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    check("rst_valid", cmd_valid, 0); check("rst_op", cmd_op, 0);
    check("rst_count", fifo_count, 0); check("rst_drop", drop_cnt, 0);
    check("rst_led", led, 0); check("rst_last", last_code, 0);

    // Single make code.
    cycle(0, 1, 8'h1D, 0, 0);
    check("t1_valid", cmd_valid, 1); check("t1_op", cmd_op, 4'b0001);
    check("t1_led", led, 4'b0001); check("t1_last", last_code, 8'h1D);
    check("t1_count", fifo_count, 1);

    // Extended make, then a non-matching break.
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 8'hE0, 0, 0); cycle(0, 1, 8'h6B, 0, 0);
    cycle(0, 1, 8'hF0, 0, 0); cycle(0, 1, 8'h1C, 0, 0);
    check("t2_count", fifo_count, 1); check("t2_op", cmd_op, 4'b0100);
    check("t2_last", last_code, 8'h1C);
    cycle(0, 1, 8'h1B, 0, 0);
    check("t2_idle", fifo_count, 2);

    // Button and PS/2 in the same cycle.
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 8'h23, 4'b0010, 0);
    check("t3_count1", fifo_count, 1); check("t3_op1", cmd_op, 4'b0010);
    cycle(0, 0, 0, 0, 0);
    check("t3_count2", fifo_count, 2);
    cycle(0, 0, 0, 0, 1);
    check("t3_op2", cmd_op, 4'b1000);

    // Overflow, then write and pop together while full.
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 8'h1D, 0, 0); cycle(0, 1, 8'h1B, 0, 0); cycle(0, 1, 8'h1C, 0, 0);
    cycle(0, 1, 8'h23, 0, 0); cycle(0, 1, 8'h1D, 0, 0);
    check("t4_count", fifo_count, 4); check("t4_drop", drop_cnt, 1);
    cycle(0, 1, 8'h1B, 0, 1);
    check("t4_full_rw_count", fifo_count, 4); check("t4_full_rw_drop", drop_cnt, 1);

    // Reset discards a pending E0 prefix.
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 8'hE0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    check("t5_count", fifo_count, 0); check("t5_last", last_code, 0);
    cycle(0, 1, 8'h75, 0, 0);
    check("t5_nocmd", fifo_count, 0); check("t5_last75", last_code, 8'h75);

`ifdef TETRIS_CMD_ARBITER_AUTO_REPEAT_EN
    // Auto-repeat timing with the key held and the consumer always ready.
    cycle(1, 0, 0, 0, 1);
    cycle(0, 1, 8'h1B, 0, 1);
    for (int i = 1; i <= 22; i++) begin
      check("rpt_valid", cmd_valid, (i == 1 || i == 11 || i == 16 || i == 21));
      cycle(0, 0, 0, 0, 1);
    end
    cycle(0, 1, 8'hF0, 0, 1);
    cycle(0, 1, 8'h1B, 0, 1);
    for (int i = 0; i < 20; i++) begin
      check("rpt_stopped", cmd_valid, 0);
      cycle(0, 0, 0, 0, 1);
    end
`endif

    // Random traffic against the model.
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 2000; i++) begin
      bit         r, pv, rdy;
      logic [3:0] bp;
      r   = ($urandom_range(0, 299) == 0);
      pv  = ($urandom_range(0, 2) == 0);
      bp  = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      rdy = ($urandom_range(0, 2) != 0) && (i % 200 > 40);
      cycle(r, pv, rand_byte(), bp, rdy);
    end
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 1);
    @(negedge clk); #1;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
